// File: rtl/cnn_stream_host.sv
// cnn_stream_host: host-side sequencer for the conv accelerator's byte-load port.
// Accepts a valid/ready byte stream and replays it to the accelerator, first the
// W_BYTES weight bytes (acc_mode = 1), then cfg_num_pics pictures of PIC_BYTES
// bytes each (acc_mode = 0). Every rising edge of acc_out_flag captures acc_dout
// together with a running picture index into a small first-word-fall-through FIFO.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_start, cfg_num_pics    run start pulse (IDLE only) and picture count
//   s_valid, s_data, s_ready   input byte stream
//   acc_mode, acc_din,
//   acc_ram_en                 registered drive of the accelerator load port
//   acc_dout, acc_out_flag     accelerator result byte and its strobe
//   r_valid, r_data, r_index,
//   r_ready                    result stream (FIFO head)
//   busy, done, ovf            status: not idle, end-of-run pulse, sticky drop
module cnn_stream_host #(
    parameter int unsigned W_BYTES   = 54,
    parameter int unsigned PIC_BYTES = 64,
    parameter int unsigned NPIC_W    = 8,
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [NPIC_W-1:0] cfg_num_pics,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              acc_mode,
    output logic [7:0]        acc_din,
    output logic              acc_ram_en,
    input  logic [7:0]        acc_dout,
    input  logic              acc_out_flag,
    output logic              r_valid,
    output logic [7:0]        r_data,
    output logic [NPIC_W-1:0] r_index,
    input  logic              r_ready,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned MAX_BYTES = (W_BYTES > PIC_BYTES) ? W_BYTES : PIC_BYTES;
    localparam int unsigned CNT_W     = $clog2(MAX_BYTES);
    localparam int unsigned AW        = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_D, DRAIN} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [NPIC_W-1:0] r_npics;
    logic [NPIC_W-1:0] r_pic_cnt;
    logic [NPIC_W-1:0] r_res_cnt;
    logic [NPIC_W-1:0] r_res_idx;
    logic              r_flag_q;
    logic              r_ovf;
    logic [7:0]        r_mem_data [RES_DEPTH];
    logic [NPIC_W-1:0] r_mem_idx  [RES_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic              w_loading;
    logic              w_hs;
    logic              w_start;
    logic              w_edge;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_w_last;
    logic              w_p_last;
    logic [NPIC_W-1:0] w_pic_nxt;
    logic              w_done;

    assign w_loading = (r_state == LOAD_W) || (r_state == LOAD_D);
    assign w_hs      = s_valid & w_loading;
    assign w_start   = (r_state == IDLE) & cfg_start;
    assign w_edge    = acc_out_flag & ~r_flag_q;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(RES_DEPTH));
    assign w_pop     = r_ready & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push    = w_edge & (~w_full | w_pop);
    assign w_w_last  = (r_byte_cnt == CNT_W'(W_BYTES - 1));
    assign w_p_last  = (r_byte_cnt == CNT_W'(PIC_BYTES - 1));
    assign w_pic_nxt = r_pic_cnt + NPIC_W'(1);
    // Dropped results still advance r_res_cnt, so this always terminates.
    assign w_done    = (r_state == DRAIN) && (r_res_cnt == r_npics) && w_empty;

    assign s_ready = w_loading;
    assign busy    = (r_state != IDLE);
    assign done    = w_done;
    assign ovf     = r_ovf;
    assign r_valid = ~w_empty;
    assign r_data  = r_mem_data[r_rd_ptr];
    assign r_index = r_mem_idx[r_rd_ptr];

    // Load sequencer; acc_* are registered one cycle behind the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            r_npics    <= '0;
            r_pic_cnt  <= '0;
            acc_mode   <= 1'b0;
            acc_din    <= '0;
            acc_ram_en <= 1'b0;
        end else begin
            acc_ram_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_npics    <= cfg_num_pics;
                        r_pic_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_hs) begin
                        acc_din    <= s_data;
                        acc_mode   <= 1'b1;
                        acc_ram_en <= 1'b1;
                        if (w_w_last) begin
                            r_byte_cnt <= '0;
                            r_state    <= (r_npics == '0) ? DRAIN : LOAD_D;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_D: begin
                    if (w_hs) begin
                        acc_din    <= s_data;
                        acc_mode   <= 1'b0;
                        acc_ram_en <= 1'b1;
                        if (w_p_last) begin
                            r_byte_cnt <= '0;
                            r_pic_cnt  <= w_pic_nxt;
                            if (w_pic_nxt == r_npics) begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result capture and FIFO; active in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_q  <= 1'b0;
            r_ovf     <= 1'b0;
            r_res_cnt <= '0;
            r_res_idx <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            for (int i = 0; i < int'(RES_DEPTH); i++) begin
                r_mem_data[i] <= '0;
                r_mem_idx[i]  <= '0;
            end
        end else begin
            r_flag_q <= acc_out_flag;
            if (w_start) begin
                r_ovf     <= 1'b0;
                r_res_cnt <= '0;
                r_res_idx <= '0;
            end
            if (w_edge) begin
                r_res_idx <= r_res_idx + NPIC_W'(1);
                r_res_cnt <= r_res_cnt + NPIC_W'(1);
                if (!w_push) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= acc_dout;
                r_mem_idx[r_wr_ptr]  <= r_res_idx;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: doc/cnn_stream_host.md
Name: cnn_stream_host

Overview:
- Synthesizable host-side sequencer for the conv accelerator's byte-load interface (`mode`, `din`, `ram_en` in; `dout`, `out_data_flag` out).
- Takes a valid/ready byte stream and drives the accelerator's load port: first the 54 weight bytes, then N pictures of 64 bytes each.
- Captures one signed 8-bit result per picture on each rising edge of `out_data_flag` and queues it for a downstream consumer.
- Replaces the bench-only driver and checker so the accelerator can sit behind a real bus.

Parameters:
- W_BYTES, 54, weight bytes per load (3x3x3x2).
- PIC_BYTES, 64, data bytes per picture (8x8x1).
- NPIC_W, 8, width of picture count and result index.
- RES_DEPTH, 4, result FIFO depth (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; honoured only in IDLE
- cfg_num_pics  in  NPIC_W  number of pictures; sampled on start
- s_valid  in  1  input byte valid
- s_data  in  8  input byte (weights first, then picture data)
- s_ready  out  1  input byte accepted when s_valid & s_ready
- acc_mode  out  1  to accelerator `mode` (1 = weight, 0 = data)
- acc_din  out  8  to accelerator `din`
- acc_ram_en  out  1  to accelerator `ram_en`
- acc_dout  in  8  from accelerator `dout`
- acc_out_flag  in  1  from accelerator `out_data_flag`
- r_valid  out  1  result available
- r_data  out  8  result byte (signed)
- r_index  out  NPIC_W  picture index of the result
- r_ready  in  1  result consumed when r_valid & r_ready
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at end of run
- ovf  out  1  sticky result-drop flag; cleared by cfg_start

Behaviour:
- Reset values: all outputs 0. FSM = IDLE; counters, FIFO and edge-detect register cleared.
- FSM states IDLE, LOAD_W, LOAD_D, DRAIN.
- IDLE:
  - s_ready = 0.
  - cfg_start latches npics and clears ovf, the picture counter, the result counter and the result index → LOAD_W.
- LOAD_W:
  - s_ready = 1.
  - Each handshake registers acc_din <= s_data, acc_mode <= 1, acc_ram_en <= 1 for exactly one cycle. Latency from handshake to acc_ram_en is 1 cycle.
  - No handshake that cycle: acc_ram_en <= 0, acc_din and acc_mode hold their values.
  - byte_cnt counts 0..W_BYTES-1. The handshake at W_BYTES-1 clears byte_cnt and moves to LOAD_D, or to DRAIN if npics == 0.
- LOAD_D:
  - Same as LOAD_W with acc_mode <= 0.
  - byte_cnt wraps at PIC_BYTES-1 and pic_cnt increments. The wrap on the last picture → DRAIN.
  - Back-to-back pictures carry no gap cycle.
- DRAIN:
  - s_ready = 0, acc_ram_en = 0.
  - When res_cnt == npics and the FIFO is empty: done = 1 for one cycle → IDLE.
  - With npics == 0, done fires the cycle after entering DRAIN.
- Result capture runs in every state:
  - flag_q <= acc_out_flag; a rising edge is `acc_out_flag & ~flag_q`.
  - On an edge, push {acc_dout, res_idx} into the FIFO, then res_idx++ and res_cnt++.
  - FIFO full and no pop in the same cycle: drop the result, set ovf. res_idx and res_cnt still increment so DRAIN terminates.
  - Push and pop in the same cycle on a full FIFO: both succeed.
- Result port:
  - r_valid = FIFO not empty; r_data and r_index show the head entry (first-word-fall-through).
  - r_valid must stay high with stable data until r_ready.
- Boundaries:
  - cfg_start outside IDLE is ignored.
  - A flag held high for several cycles counts as one result.
  - res_idx wraps modulo 2^NPIC_W.
  - Async reset mid-run aborts immediately; the partial weight or picture load is discarded and must be reloaded from scratch.

Test Plan:
- Weight load: start with num_pics = 1, drive 54 weight bytes back-to-back with s_valid = 1 → acc_ram_en high for exactly 54 consecutive cycles, acc_mode = 1, acc_din equals the input sequence delayed 1 cycle.
- Picture streaming: num_pics = 2 → after the weights, 128 data beats with acc_mode = 0 and no gap between the two pictures. A model `out_data_flag` rising with dout = 0xF3, then 0x05 → results (-13, idx 0) and (5, idx 1), followed by one done pulse.
- Bubbles: drop s_valid for 1 of every 2 cycles → acc_ram_en = 0 in those slots, acc_din holds, total beats still 54 + 64.
- Backpressure/overflow: r_ready = 0 with 5 flag edges and RES_DEPTH = 4 → 4 entries kept (idx 0..3), ovf = 1, done still fires after the FIFO drains once r_ready = 1.
- num_pics = 0 → 54 weight beats, then done; no data beats, busy falls the cycle after done.
- Reset mid-load: assert rst_n = 0 after 30 weight bytes → all outputs 0 at once. A new cfg_start restarts the load with acc_mode = 1 from byte 0.
